// File: rtl/fetch_unit.sv
// Stage-1 instruction fetch: owns the PC, issues in-order imem requests under a
// credit limit, buffers responses for decode and discards stale ones after redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     ib_cnt_q, ib_cnt_d;
  logic [AW-1:0]     ib_rd_q, ib_rd_d, ib_wr_q, ib_wr_d;
  logic [AW-1:0]     af_rd_q, af_rd_d, af_wr_q, af_wr_d;
  logic [31:0]       ib_data_q [BUF_DEPTH];
  logic [31:0]       ib_data_d [BUF_DEPTH];
  logic [31:0]       ib_addr_q [BUF_DEPTH];
  logic [31:0]       ib_addr_d [BUF_DEPTH];
  logic [31:0]       af_addr_q [BUF_DEPTH];
  logic [31:0]       af_addr_d [BUF_DEPTH];

  logic [CW:0]       in_use;
  logic              credits_ok;
  logic              req_fire;
  logic              resp_take;
  logic              resp_keep;
  logic              ib_pop;

  // Stale responses still occupy memory-side slots, so drop counts against credit in DRAIN.
  always_comb begin
    in_use = {1'b0, outstanding_q} + {1'b0, ib_cnt_q};
    if (state_q == DRAIN) begin
      in_use = in_use + {1'b0, drop_q};
    end
    credits_ok = in_use < DEPTH_W;
  end

  assign imem_req_valid = credits_ok & ~redirect_valid & rst_n;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_take      = imem_resp_valid & ((drop_q != '0) | (outstanding_q != '0));
  assign resp_keep      = resp_take & (drop_q == '0) & ~redirect_valid;
  assign ib_pop         = (ib_cnt_q != '0) & dec_ready & ~redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    ib_cnt_d      = ib_cnt_q;
    ib_rd_d       = ib_rd_q;
    ib_wr_d       = ib_wr_q;
    af_rd_d       = af_rd_q;
    af_wr_d       = af_wr_q;
    ib_data_d     = ib_data_q;
    ib_addr_d     = ib_addr_q;
    af_addr_d     = af_addr_q;

    if (resp_take) begin
      af_rd_d = af_rd_q + AW'(1);
    end

    if (redirect_valid) begin
      pc_d          = redirect_pc & ~32'h3;
      outstanding_d = '0;
      drop_d        = drop_q + outstanding_q - CW'(resp_take);
      ib_cnt_d      = '0;
      ib_rd_d       = '0;
      ib_wr_d       = '0;
    end else begin
      if (req_fire) begin
        pc_d               = pc_q + 32'd4;
        af_addr_d[af_wr_q] = pc_q;
        af_wr_d            = af_wr_q + AW'(1);
      end
      if (resp_take && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (resp_keep) begin
        ib_data_d[ib_wr_q] = imem_resp_data;
        ib_addr_d[ib_wr_q] = af_addr_q[af_rd_q];
        ib_wr_d            = ib_wr_q + AW'(1);
      end
      if (ib_pop) begin
        ib_rd_d = ib_rd_q + AW'(1);
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_keep);
      ib_cnt_d      = ib_cnt_q + CW'(resp_keep) - CW'(ib_pop);
    end

    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      ib_cnt_q      <= '0;
      ib_rd_q       <= '0;
      ib_wr_q       <= '0;
      af_rd_q       <= '0;
      af_wr_q       <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        ib_data_q[i] <= '0;
        ib_addr_q[i] <= '0;
        af_addr_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      ib_cnt_q      <= ib_cnt_d;
      ib_rd_q       <= ib_rd_d;
      ib_wr_q       <= ib_wr_d;
      af_rd_q       <= af_rd_d;
      af_wr_q       <= af_wr_d;
      ib_data_q     <= ib_data_d;
      ib_addr_q     <= ib_addr_d;
      af_addr_q     <= af_addr_d;
    end
  end

  assign instr_valid    = (ib_cnt_q != '0);
  assign instr_out      = instr_valid ? ib_data_q[ib_rd_q] : NOP;
  assign instr_addr_out = instr_valid ? ib_addr_q[ib_rd_q] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory with random latency, transaction-level
// model of fetched/buffered/stale words, directed scenarios then random traffic.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_addr_out;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_addr_out(instr_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    bit          stale;
  } mreq_t;

  mreq_t       mem_q[$];   // accepted requests not yet answered, oldest first
  logic [31:0] buf_q[$];   // addresses of live words waiting for decode
  logic [31:0] exp_pc;
  int          cyc;
  int          last_due;
  int          lat_lo;
  int          lat_hi;
  int          n_cmp;
  int          n_fail;

  function automatic logic [31:0] image(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_bound(input string tag, input bit ok);
    n_cmp++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: observed timeout expected event (cycle %0d)", tag, cyc);
    end
  endtask

  task automatic model_clear();
    mem_q.delete();
    buf_q.delete();
    exp_pc   = RESET_PC;
    last_due = -1;
  endtask

  // One clock cycle: drive, check at #1, then advance the model at the edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit dready, input bit rready);
    bit    resp;
    bit    exp_rv;
    bit    exp_iv;
    bit    do_pop;
    int    lat;
    mreq_t e;
    resp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    redirect_valid  = redir;
    redirect_pc     = rpc;
    dec_ready       = dready;
    imem_req_ready  = rready;
    imem_resp_valid = resp;
    imem_resp_data  = resp ? image(mem_q[0].addr) : $urandom;
    #1;
    exp_rv = !redir && ((mem_q.size() + buf_q.size()) < DEPTH);
    exp_iv = buf_q.size() > 0;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    chk("req_addr", imem_req_addr, exp_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
    chk("instr_addr", instr_addr_out, exp_iv ? buf_q[0] : 32'h0);
    chk("instr_data", instr_out, exp_iv ? image(buf_q[0]) : NOP);
    @(posedge clk);
    if (redir) begin
      if (resp) void'(mem_q.pop_front());
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      buf_q.delete();
      exp_pc = rpc & ~32'h3;
    end else begin
      do_pop = exp_iv && dready;
      if (do_pop) void'(buf_q.pop_front());
      if (resp) begin
        e = mem_q.pop_front();
        if (!e.stale) buf_q.push_back(e.addr);
      end
      if (exp_rv && rready) begin
        lat     = $urandom_range(lat_hi, lat_lo);
        e.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        e.addr  = exp_pc;
        e.stale = 1'b0;
        last_due = e.due;
        mem_q.push_back(e);
        exp_pc = exp_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    dec_ready       = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr_out", instr_out, NOP);
    chk("rst_instr_addr", instr_addr_out, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    lat_lo = 1;
    lat_hi = 1;
    rst_n  = 1'b0;
    model_clear();
    do_reset();

    // Streaming, latency 1, decode always ready.
    repeat (12) step(1'b0, '0, 1'b1, 1'b1);

    // Decode stall: buffer fills to depth, requests stop, nothing lost afterwards.
    repeat (10) step(1'b0, '0, 1'b0, 1'b1);
    chk("stall_full", {31'b0, instr_valid}, 32'h1);
    chk("stall_no_req", {31'b0, imem_req_valid}, 32'h0);
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);

    // Redirect with two requests in flight at latency 3.
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() == 2) found = 1'b1;
      else step(1'b0, '0, 1'b1, 1'b1);
    end
    chk_bound("two_outstanding", found);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    chk("redir_pc", imem_req_addr, 32'h0000_0100);
    repeat (16) step(1'b0, '0, 1'b1, 1'b1);

    // Unaligned redirect coinciding with a response.
    lat_lo = 2;
    lat_hi = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
      else step(1'b0, '0, 1'b1, 1'b1);
    end
    chk_bound("resp_due", found);
    step(1'b1, 32'h0000_0203, 1'b1, 1'b1);
    chk("redir_align", imem_req_addr, 32'h0000_0200);
    repeat (12) step(1'b0, '0, 1'b1, 1'b1);

    // Memory not ready: address and pc hold.
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // PC wrap at the top of the address space.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() == 0 && buf_q.size() == 0) found = 1'b1;
      else step(1'b0, '0, 1'b1, 1'b0);
    end
    chk_bound("drained", found);
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("pc_wrap", imem_req_addr, 32'h0000_0000);
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);

    // Fill the buffer, then reset mid-stream.
    lat_lo = 1;
    lat_hi = 1;
    repeat (8) step(1'b0, '0, 1'b0, 1'b1);
    chk("full_before_reset", {31'b0, instr_valid}, 32'h1);
    do_reset();
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // Random traffic: latencies, back-pressure, stalls and redirects.
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 800; i++) begin
      bit          r;
      logic [31:0] tgt;
      r   = ($urandom_range(99, 0) < 6);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      step(r, tgt, ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
      if (i == 400) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
